// File: rtl/stack_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stack_ctrl_pkg
// Purpose  : Opcodes, FSM state encoding and precondition helpers for stack_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package stack_ctrl_pkg;

  localparam logic [2:0] c_op_nop  = 3'd0;
  localparam logic [2:0] c_op_push = 3'd1;
  localparam logic [2:0] c_op_pop  = 3'd2;
  localparam logic [2:0] c_op_add  = 3'd3;
  localparam logic [2:0] c_op_sub  = 3'd4;
  localparam logic [2:0] c_op_and  = 3'd5;
  localparam logic [2:0] c_op_dup  = 3'd6;
  localparam logic [2:0] c_op_swap = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP1  = 3'd1,
    S_POP2  = 3'd2,
    S_WAIT  = 3'd3,
    S_PUSH1 = 3'd4,
    S_PUSH2 = 3'd5,
    S_RESP  = 3'd6
  } state_e;

  function automatic logic needs_two_pops(input logic [2:0] op);
    return (op == c_op_add) || (op == c_op_sub) ||
           (op == c_op_and) || (op == c_op_swap);
  endfunction

  function automatic logic cmd_allowed(input logic [2:0] op,
                                       input int unsigned cnt,
                                       input int unsigned depth);
    logic ok;
    ok = 1'b1;
    case (op)
      c_op_push: ok = (cnt < depth);
      c_op_pop:  ok = (cnt >= 32'd1);
      c_op_dup:  ok = (cnt >= 32'd1) && (cnt < depth);
      c_op_add, c_op_sub, c_op_and, c_op_swap: ok = (cnt >= 32'd2);
      default:   ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stack_alu.sv
`default_nettype none
// ============================================================================
// Module   : stack_alu
// Purpose  : Combinational result for two-operand ops; a is the old top, b below.
// Revision : 1.0 - initial release
// ============================================================================
module stack_alu
  import stack_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      c_op_add: result = b + a;
      c_op_sub: result = b - a;
      c_op_and: result = b & a;
      default:  result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stack_ctrl
// Purpose  : Command-driven controller sequencing push/pop traffic to an external stack.
// Revision : 1.0 - initial release
// ============================================================================
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [2:0]                   cmd_op,
  input  logic [WIDTH-1:0]             cmd_imm,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [WIDTH-1:0]             resp_data,
  output logic                         resp_err,
  output logic                         stk_push,
  output logic                         stk_pop,
  output logic [WIDTH-1:0]             stk_data_in,
  input  logic [WIDTH-1:0]             stk_data_out,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  state_e           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             stk_push_q;
  logic             stk_pop_q;
  logic [WIDTH-1:0] stk_data_in_q;
  logic             resp_valid_q;
  logic             resp_err_q;
  logic [WIDTH-1:0] resp_data_q;
  logic [WIDTH-1:0] alu_result;

  stack_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (stk_data_out),
    .result (alu_result)
  );

  // Occupancy tracks the pulses actually issued, so it stays aligned with the stack.
  assign count_d = count_q + CW'(stk_push_q) - CW'(stk_pop_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      op_q          <= c_op_nop;
      imm_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      res_q         <= '0;
      count_q       <= '0;
      stk_push_q    <= 1'b0;
      stk_pop_q     <= 1'b0;
      stk_data_in_q <= '0;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_data_q   <= '0;
    end else begin
      stk_push_q    <= 1'b0;
      stk_pop_q     <= 1'b0;
      stk_data_in_q <= '0;
      count_q       <= count_d;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            imm_q <= cmd_imm;
            if (!cmd_allowed(cmd_op, 32'(count_q), DEPTH)) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_data_q  <= '0;
            end else begin
              case (cmd_op)
                c_op_nop: begin
                  state_q      <= S_RESP;
                  resp_valid_q <= 1'b1;
                  resp_data_q  <= '0;
                end
                c_op_push: begin
                  state_q       <= S_PUSH1;
                  stk_push_q    <= 1'b1;
                  stk_data_in_q <= cmd_imm;
                end
                default: begin
                  state_q   <= S_POP1;
                  stk_pop_q <= 1'b1;
                end
              endcase
            end
          end
        end
        S_POP1: begin
          if (needs_two_pops(op_q)) begin
            state_q   <= S_POP2;
            stk_pop_q <= 1'b1;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_POP2: begin
          a_q     <= stk_data_out;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // stk_data_out now holds the most recently popped word.
          case (op_q)
            c_op_pop: begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_data_q  <= stk_data_out;
            end
            c_op_dup: begin
              a_q           <= stk_data_out;
              res_q         <= stk_data_out;
              state_q       <= S_PUSH1;
              stk_push_q    <= 1'b1;
              stk_data_in_q <= stk_data_out;
            end
            c_op_swap: begin
              b_q           <= stk_data_out;
              res_q         <= stk_data_out;
              state_q       <= S_PUSH1;
              stk_push_q    <= 1'b1;
              stk_data_in_q <= a_q;
            end
            default: begin
              b_q           <= stk_data_out;
              res_q         <= alu_result;
              state_q       <= S_PUSH1;
              stk_push_q    <= 1'b1;
              stk_data_in_q <= alu_result;
            end
          endcase
        end
        S_PUSH1: begin
          if (op_q == c_op_dup) begin
            state_q       <= S_PUSH2;
            stk_push_q    <= 1'b1;
            stk_data_in_q <= a_q;
          end else if (op_q == c_op_swap) begin
            state_q       <= S_PUSH2;
            stk_push_q    <= 1'b1;
            stk_data_in_q <= b_q;
          end else begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_data_q  <= (op_q == c_op_push) ? imm_q : res_q;
          end
        end
        S_PUSH2: begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_data_q  <= res_q;
        end
        S_RESP: begin
          if (resp_ready) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready   = rst && (state_q == S_IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign resp_err    = resp_err_q;
  assign stk_push    = stk_push_q;
  assign stk_pop     = stk_pop_q;
  assign stk_data_in = stk_data_in_q;
  assign count       = count_q;

endmodule
`default_nettype wire

// File: tb/tb_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_ctrl
// Purpose  : Directed vector bench for stack_ctrl with a behavioural attached stack.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stack_ctrl;

  localparam logic [2:0] NOP = 3'd0, PSH = 3'd1, POP = 3'd2, ADD = 3'd3,
                         SUB = 3'd4, AND = 3'd5, DUP = 3'd6, SWP = 3'd7;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [7:0] cmd_imm = 8'd0;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic [7:0] resp_data;
  logic       resp_err;
  logic       stk_push;
  logic       stk_pop;
  logic [7:0] stk_data_in;
  logic [7:0] stk_data_out;
  logic [1:0] count;

  int checks = 0;
  int failures = 0;

  stack_ctrl #(.WIDTH(8), .DEPTH(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_imm      (cmd_imm),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_err     (resp_err),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_data_in  (stk_data_in),
    .stk_data_out (stk_data_out),
    .count        (count)
  );

  always #5 clk = ~clk;

  // Attached stack: registered top output, shares the controller reset.
  logic [7:0] mem [0:7];
  logic [3:0] sp;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp           <= 4'd0;
      stk_data_out <= 8'd0;
    end else if (stk_push && sp < 4'd8) begin
      mem[sp[2:0]] <= stk_data_in;
      sp           <= sp + 4'd1;
    end else if (stk_pop && sp > 4'd0) begin
      stk_data_out <= mem[3'(sp - 4'd1)];
      sp           <= sp - 4'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("push_pop_exclusive", {31'd0, stk_push & stk_pop}, 32'd0);
      if (!stk_push) check("data_in_zero_when_idle", {24'd0, stk_data_in}, 32'd0);
    end
  end

  task automatic do_cmd(input logic [2:0] op, input logic [7:0] imm,
                        input int hold, input logic [7:0] hold_exp,
                        output logic [7:0] data, output logic err, output int lat,
                        output int npush, output int npop, output logic [1:0] cnt);
    int w;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_imm   = imm;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_imm   = 8'd0;
    lat = 0; npush = 0; npop = 0;
    for (int n = 1; n <= 20; n++) begin
      if (stk_push) npush++;
      if (stk_pop) npop++;
      if (resp_valid) begin
        lat = n;
        break;
      end
      @(posedge clk);
      #1;
    end
    data = resp_data;
    err  = resp_err;
    cnt  = count;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_resp_data", {24'd0, resp_data}, {24'd0, hold_exp});
      check("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] imm;
    logic       err;
    logic [7:0] data;
    logic [1:0] cnt;
    int         lat;
  } vec_t;

  function automatic int exp_pushes(input logic [2:0] op, input logic err);
    if (err) return 0;
    case (op)
      PSH, ADD, SUB, AND: return 1;
      DUP, SWP:           return 2;
      default:            return 0;
    endcase
  endfunction

  function automatic int exp_pops(input logic [2:0] op, input logic err);
    if (err) return 0;
    case (op)
      POP, DUP:           return 1;
      ADD, SUB, AND, SWP: return 2;
      default:            return 0;
    endcase
  endfunction

  vec_t vecs[$];
  logic [7:0] d;
  logic e;
  int l, np, npp;
  logic [1:0] c;
  logic found;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs.push_back('{PSH, 8'hAA, 1'b0, 8'hAA, 2'd1, 2});
    vecs.push_back('{PSH, 8'hBB, 1'b0, 8'hBB, 2'd2, 2});
    vecs.push_back('{PSH, 8'hCC, 1'b0, 8'hCC, 2'd3, 2});
    vecs.push_back('{PSH, 8'hDD, 1'b1, 8'h00, 2'd3, 1});
    vecs.push_back('{POP, 8'h00, 1'b0, 8'hCC, 2'd2, 3});
    vecs.push_back('{POP, 8'h00, 1'b0, 8'hBB, 2'd1, 3});
    vecs.push_back('{POP, 8'h00, 1'b0, 8'hAA, 2'd0, 3});
    vecs.push_back('{PSH, 8'h05, 1'b0, 8'h05, 2'd1, 2});
    vecs.push_back('{PSH, 8'h03, 1'b0, 8'h03, 2'd2, 2});
    vecs.push_back('{ADD, 8'h00, 1'b0, 8'h08, 2'd1, 5});
    vecs.push_back('{POP, 8'h00, 1'b0, 8'h08, 2'd0, 3});
    vecs.push_back('{PSH, 8'h03, 1'b0, 8'h03, 2'd1, 2});
    vecs.push_back('{PSH, 8'h05, 1'b0, 8'h05, 2'd2, 2});
    vecs.push_back('{SUB, 8'h00, 1'b0, 8'hFE, 2'd1, 5});
    vecs.push_back('{POP, 8'h00, 1'b0, 8'hFE, 2'd0, 3});
    vecs.push_back('{PSH, 8'hFF, 1'b0, 8'hFF, 2'd1, 2});
    vecs.push_back('{PSH, 8'h02, 1'b0, 8'h02, 2'd2, 2});
    vecs.push_back('{ADD, 8'h00, 1'b0, 8'h01, 2'd1, 5});
    vecs.push_back('{DUP, 8'h00, 1'b0, 8'h01, 2'd2, 5});
    vecs.push_back('{POP, 8'h00, 1'b0, 8'h01, 2'd1, 3});
    vecs.push_back('{POP, 8'h00, 1'b0, 8'h01, 2'd0, 3});
    vecs.push_back('{PSH, 8'h11, 1'b0, 8'h11, 2'd1, 2});
    vecs.push_back('{PSH, 8'h22, 1'b0, 8'h22, 2'd2, 2});
    vecs.push_back('{SWP, 8'h00, 1'b0, 8'h11, 2'd2, 6});
    vecs.push_back('{POP, 8'h00, 1'b0, 8'h11, 2'd1, 3});
    vecs.push_back('{POP, 8'h00, 1'b0, 8'h22, 2'd0, 3});
    vecs.push_back('{POP, 8'h00, 1'b1, 8'h00, 2'd0, 1});
    vecs.push_back('{NOP, 8'h5C, 1'b0, 8'h00, 2'd0, 1});
    vecs.push_back('{DUP, 8'h00, 1'b1, 8'h00, 2'd0, 1});
    vecs.push_back('{PSH, 8'h0F, 1'b0, 8'h0F, 2'd1, 2});
    vecs.push_back('{PSH, 8'h3C, 1'b0, 8'h3C, 2'd2, 2});
    vecs.push_back('{AND, 8'h00, 1'b0, 8'h0C, 2'd1, 5});
    vecs.push_back('{ADD, 8'h00, 1'b1, 8'h00, 2'd1, 1});
    vecs.push_back('{SWP, 8'h00, 1'b1, 8'h00, 2'd1, 1});
    vecs.push_back('{PSH, 8'h01, 1'b0, 8'h01, 2'd2, 2});
    vecs.push_back('{PSH, 8'h02, 1'b0, 8'h02, 2'd3, 2});
    vecs.push_back('{DUP, 8'h00, 1'b1, 8'h00, 2'd3, 1});
    vecs.push_back('{SWP, 8'h00, 1'b0, 8'h01, 2'd3, 6});
    vecs.push_back('{POP, 8'h00, 1'b0, 8'h01, 2'd2, 3});
    vecs.push_back('{SUB, 8'h00, 1'b0, 8'h0A, 2'd1, 5});
    vecs.push_back('{POP, 8'h00, 1'b0, 8'h0A, 2'd0, 3});

    // Reset state
    #12;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_outputs", {20'd0, resp_err, stk_push, stk_pop, count, resp_data[0], stk_data_in[0], 5'd0}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("post_rst_count", {30'd0, count}, 32'd0);

    foreach (vecs[i]) begin
      do_cmd(vecs[i].op, vecs[i].imm, 0, 8'h00, d, e, l, np, npp, c);
      check($sformatf("v%0d_data", i), {24'd0, d}, {24'd0, vecs[i].data});
      check($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, vecs[i].err});
      check($sformatf("v%0d_count", i), {30'd0, c}, {30'd0, vecs[i].cnt});
      check($sformatf("v%0d_latency", i), l, vecs[i].lat);
      check($sformatf("v%0d_pushes", i), np, exp_pushes(vecs[i].op, vecs[i].err));
      check($sformatf("v%0d_pops", i), npp, exp_pops(vecs[i].op, vecs[i].err));
    end

    // Response back-pressure on POP
    do_cmd(PSH, 8'h5A, 0, 8'h00, d, e, l, np, npp, c);
    check("bp_push_count", {30'd0, c}, 32'd1);
    do_cmd(POP, 8'h00, 3, 8'h5A, d, e, l, np, npp, c);
    check("bp_pop_data", {24'd0, d}, 32'h5A);
    check("bp_pop_count", {30'd0, c}, 32'd0);
    check("bp_idle_after", {31'd0, cmd_ready}, 32'd1);

    // Reset asserted during ADD's PUSH1
    do_cmd(PSH, 8'h05, 0, 8'h00, d, e, l, np, npp, c);
    do_cmd(PSH, 8'h03, 0, 8'h00, d, e, l, np, npp, c);
    check("mid_rst_setup_count", {30'd0, c}, 32'd2);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = ADD;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    found = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (stk_push) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("mid_rst_push1_seen", {31'd0, found}, 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_push", {31'd0, stk_push}, 32'd0);
    check("mid_rst_pop", {31'd0, stk_pop}, 32'd0);
    check("mid_rst_data_in", {24'd0, stk_data_in}, 32'd0);
    check("mid_rst_resp", {23'd0, resp_valid, resp_data}, 32'd0);
    check("mid_rst_err", {31'd0, resp_err}, 32'd0);
    check("mid_rst_count", {30'd0, count}, 32'd0);
    check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_release_ready", {31'd0, cmd_ready}, 32'd1);
    do_cmd(POP, 8'h00, 0, 8'h00, d, e, l, np, npp, c);
    check("after_rst_pop_err", {31'd0, e}, 32'd1);
    check("after_rst_pop_nopulse", npp, 0);
    do_cmd(PSH, 8'h77, 0, 8'h00, d, e, l, np, npp, c);
    do_cmd(POP, 8'h00, 0, 8'h00, d, e, l, np, npp, c);
    check("after_rst_roundtrip", {24'd0, d}, 32'h77);
    check("after_rst_count", {30'd0, c}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
